// File: rtl/fft_pkg.sv
// Shared types and helpers for the configurable R2-SDF FFT stages:
// twiddle generation, rounding shift, saturation and size clamping.
package fft_pkg;

    typedef enum logic {PhFill = 1'b0, PhCalc = 1'b1} phase_e;

    localparam int unsigned ArithW = 48;
    typedef logic signed [ArithW-1:0] acc_t;

    localparam real Pi = 3.141592653589793;

    function automatic int round_real(real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // Twiddle table entry i of an n-point table, Q1.(w-1)
    function automatic int tw_re(int i, int n, int w);
        real ang;
        ang = 2.0 * Pi * real'(i) / real'(n);
        return round_real((2.0 ** (w - 1) - 1.0) * $cos(ang));
    endfunction

    function automatic int tw_im(int i, int n, int w);
        real ang;
        ang = 2.0 * Pi * real'(i) / real'(n);
        return -round_real((2.0 ** (w - 1) - 1.0) * $sin(ang));
    endfunction

    // Arithmetic right shift with round-half-up
    function automatic acc_t round_shift(acc_t x, int unsigned sh);
        return (x + (acc_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic acc_t saturate(acc_t x, int unsigned w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - 1;
        lo = -(acc_t'(1) <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int clamp_log2n(int v, int vmax);
        if (v < 1) return 1;
        if (v > vmax) return vmax;
        return v;
    endfunction

endpackage

// File: rtl/fft_sdf_stage_cfg_buffer.sv
// Feedback delay storage for one SDF stage; a read returns the word held
// before any write to the same address in that cycle.
module sdf_delay_buffer #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/fft_sdf_stage_cfg.sv
// Self-sequencing radix-2 SDF FFT stage with runtime transform size.
// Optional per-beat butterfly halving when FFT_STAGE_SCALE_EN is defined.
module fft_sdf_stage_cfg #(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 14,
    parameter int unsigned TW_W  = 8,
    parameter int unsigned N_MAX = 512,
    parameter int unsigned STAGE = 0,
    parameter int unsigned LOG2W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [LOG2W-1:0] log2n_i,
    input  logic             valid_i,
    input  logic [IN_W-1:0]  re_i,
    input  logic [IN_W-1:0]  im_i,
    input  logic             flush_i,
`ifdef FFT_STAGE_SCALE_EN
    input  logic             scale_i,
`endif
    output logic             valid_o,
    output logic [OUT_W-1:0] re_o,
    output logic [OUT_W-1:0] im_o,
    output logic             sat_flag_o
);
    import fft_pkg::*;

    localparam int unsigned LgMax  = $clog2(N_MAX);
    localparam int unsigned CntW   = LgMax - STAGE;
    localparam int unsigned Depth  = N_MAX >> (STAGE + 1);
    localparam int unsigned AddrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned BufW   = IN_W + 1;
    localparam int unsigned TwN    = N_MAX / 2;
    localparam int unsigned TwIdxW = LgMax - 1;

    logic signed [TW_W-1:0] tw_re_tab [TwN];
    logic signed [TW_W-1:0] tw_im_tab [TwN];

    for (genvar g = 0; g < TwN; g++) begin : g_tw
        localparam int TwRe = tw_re(g, N_MAX, TW_W);
        localparam int TwIm = tw_im(g, N_MAX, TW_W);
        assign tw_re_tab[g] = TW_W'(TwRe);
        assign tw_im_tab[g] = TW_W'(TwIm);
    end

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [LOG2W-1:0] l_q, l_d;
    logic             primed_q, primed_d, sat_q, sat_d, valid_q, valid_d, frun_q, frun_d;
    logic [OUT_W-1:0] re_q, re_d, im_q, im_d;

    int               l_req, l_cur, dsh, tsh;
    logic             latch_open, active, fire, flush_beat, k_last, all_flush, out_valid, ovf;
    logic [CntW-1:0]  dlen, dmask, cmask, k;
    phase_e           phase;
    logic [TwIdxW-1:0] tw_idx;

    logic [2*BufW-1:0]      rd_data, wr_data;
    logic signed [BufW-1:0] a_re, a_im, b_re, b_im;
    acc_t ar, ai, br, bi, wr, wi, sum_re, sum_im, dif_re, dif_im;
    acc_t res_re, res_im, out_re, out_im;

    always_comb begin
        l_req      = clamp_log2n(int'(log2n_i), int'(LgMax));
        // Size follows the input directly while the stage is empty and idle
        latch_open = !primed_q && (cnt_q == '0);
        l_cur      = latch_open ? l_req : int'(l_q);
        active     = int'(STAGE) < l_cur;
        dsh        = active ? (l_cur - int'(STAGE) - 1) : 0;
        dlen       = CntW'(1) << dsh;
        dmask      = dlen - 1'b1;
        cmask      = (dlen << 1) - 1'b1;
        k          = cnt_q & dmask;
        k_last     = (k == dmask);
        phase      = ((cnt_q & dlen) != '0) ? PhCalc : PhFill;
        fire       = active && (valid_i || (flush_i && primed_q && (phase == PhFill)));
        flush_beat = fire && !valid_i;
        all_flush  = ((k == '0) || frun_q) && flush_beat;
        out_valid  = (phase == PhCalc) || primed_q;
        tsh        = int'(LgMax) - l_cur + int'(STAGE);
        tw_idx     = TwIdxW'(k) << tsh;
    end

    assign a_re = rd_data[2*BufW-1:BufW];
    assign a_im = rd_data[BufW-1:0];

    always_comb begin
        b_re   = flush_beat ? '0 : BufW'(signed'(re_i));
        b_im   = flush_beat ? '0 : BufW'(signed'(im_i));
        ar     = acc_t'(a_re);
        ai     = acc_t'(a_im);
        br     = acc_t'(b_re);
        bi     = acc_t'(b_im);
        wr     = acc_t'(tw_re_tab[tw_idx]);
        wi     = acc_t'(tw_im_tab[tw_idx]);
        sum_re = ar + br;
        sum_im = ai + bi;
        dif_re = ar - br;
        dif_im = ai - bi;
`ifdef FFT_STAGE_SCALE_EN
        if (scale_i) begin
            sum_re = round_shift(sum_re, 1);
            sum_im = round_shift(sum_im, 1);
            dif_re = round_shift(dif_re, 1);
            dif_im = round_shift(dif_im, 1);
        end
`endif
        if (phase == PhCalc) begin
            res_re  = sum_re;
            res_im  = sum_im;
            wr_data = {BufW'(dif_re), BufW'(dif_im)};
        end else begin
            res_re  = round_shift(ar * wr - ai * wi, TW_W - 1);
            res_im  = round_shift(ar * wi + ai * wr, TW_W - 1);
            wr_data = {b_re, b_im};
        end
        out_re = saturate(res_re, OUT_W);
        out_im = saturate(res_im, OUT_W);
        ovf    = (out_re != res_re) || (out_im != res_im);
    end

    sdf_delay_buffer #(
        .WIDTH(2 * BufW),
        .DEPTH(Depth),
        .AW   (AddrW)
    ) u_buf (
        .clk    (clk),
        .we_i   (fire),
        .addr_i (AddrW'(k)),
        .wdata_i(wr_data),
        .rdata_o(rd_data)
    );

    always_comb begin
        cnt_d    = cnt_q;
        primed_d = primed_q;
        sat_d    = sat_q;
        l_d      = latch_open ? LOG2W'(l_req) : l_q;
        valid_d  = 1'b0;
        re_d     = re_q;
        im_d     = im_q;
        frun_d   = frun_q;
        if (clr_i) begin
            cnt_d    = '0;
            primed_d = 1'b0;
            sat_d    = 1'b0;
            l_d      = LOG2W'(l_req);
            frun_d   = 1'b0;
        end else if (!active) begin
            valid_d = valid_i;
            if (valid_i) begin
                re_d = OUT_W'(signed'(re_i));
                im_d = OUT_W'(signed'(im_i));
            end
        end else if (fire) begin
            valid_d = out_valid;
            if (out_valid) begin
                re_d  = OUT_W'(out_re);
                im_d  = OUT_W'(out_im);
                sat_d = sat_q | ovf;
            end
            cnt_d = (cnt_q + 1'b1) & cmask;
            if (phase == PhFill) begin
                frun_d = all_flush;
                // A fill half made only of flush beats leaves the stage empty
                if (k_last && all_flush) begin
                    cnt_d    = '0;
                    primed_d = 1'b0;
                end
            end else if (k_last) begin
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            sat_q    <= 1'b0;
            l_q      <= LOG2W'(1);
            valid_q  <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
            frun_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            sat_q    <= sat_d;
            l_q      <= l_d;
            valid_q  <= valid_d;
            re_q     <= re_d;
            im_q     <= im_d;
            frun_q   <= frun_d;
        end
    end

    assign valid_o    = valid_q;
    assign re_o       = re_q;
    assign im_o       = im_q;
    assign sat_flag_o = sat_q;

endmodule
